scb_initiator: RTL and testbench
================================

SCB_INITIATOR -- requirements
Module: scb_initiator

Interface
- REQ-001: Parameter A, default 11, SCB byte-address width.
- REQ-002: Parameter D, default 16, SCB data width.
- REQ-003: Parameter B, default 2, SCB byte-strobe width (D/8).
- REQ-004: Clocking SHALL be one clock; reset is synchronous and active-high.
- REQ-005: clk_i  input  1  sole clock; all state changes on rising edge.
- REQ-006: rst_i  input  1  synchronous active-high reset.
- REQ-007: req_valid_i  input  1  command offered.
- REQ-008: req_ready_o  output  1  command accepted when valid&ready.
- REQ-009: req_wr_i  input  1  1=write, 0=read.
- REQ-010: req_word_i  input  1  1=16-bit access, 0=byte access.
- REQ-011: req_addr_i  input  A  byte address.
- REQ-012: req_wdata_i  input  D  write data; a byte write uses [7:0].
- REQ-013: rsp_valid_o  output  1  one-cycle completion pulse; no backpressure.
- REQ-014: rsp_rdata_o  output  D  read data; a byte read is zero-extended in [7:0].
- REQ-015: rsp_err_o  output  1  error flag, qualified by rsp_valid_o.
- REQ-016: scb_Addr_o  output  A  byte address; bit 0 SHALL be 0 for word cycles.
- REQ-017: scb_Data_o  output  D  write data on the selected lanes.
- REQ-018: scb_Data_i  input  D  read data, valid the cycle after an accepted read.
- REQ-019: scb_stb_o  output  B  lane strobes: [0]=even byte [7:0], [1]=odd byte [15:8].
- REQ-020: scb_ce_o, scb_rd_o, scb_wr_o  output  1 each  chip enable, read strobe, write strobe.
- REQ-021: scb_rdy_i  input  1  responder ready; a bus cycle completes on a clock where scb_ce_o&scb_rdy_i.

Function
- REQ-022: FSM states SHALL be IDLE, CYC1, DAT1, CYC2, DAT2, RSP; req_ready_o=1 only in IDLE.
- REQ-023: Accept in IDLE: go to CYC1; all scb_* outputs are registered and valid in CYC1.
- REQ-024: In CYCn, scb_ce_o=1 and exactly one of scb_rd_o/scb_wr_o=1, held stable until scb_rdy_i=1.
- REQ-025: rdy=1 on a read SHALL go to DATn, which captures the addressed lane(s) of scb_Data_i; rdy=1 on a write skips DATn.
- REQ-026: After the last bus cycle the FSM SHALL enter RSP: rsp_valid_o=1 for one cycle, then IDLE.
- REQ-027: Aligned word read with rdy=1: accept at N, rsp_valid_o at N+3; aligned write: rsp_valid_o at N+2.
- REQ-028: Byte access SHALL drive stb=01 for an even address and 10 for an odd address; write data is replicated to both lanes.
- REQ-029: Word access at an even address SHALL be one cycle with stb=11.
- REQ-030: Word access at an odd address (with split enabled) SHALL be two byte cycles:
  - the low byte at addr on stb=10;
  - then the high byte at addr+1 (mod 2^A) on stb=01.
  - Example: 0x7FF wraps to 0x000.
- REQ-031: Split-word read data SHALL be assembled as {byte(addr+1), byte(addr)}.
- REQ-032: Wait timeout: an 8-bit counter counts CYCn clocks with rdy=0.
  - Reaching 255 SHALL drop all strobes and go to RSP with rsp_err_o=1, rsp_rdata_o=0.
  - The counter clears at each CYCn entry.
- REQ-033: scb_ce_o, scb_rd_o, scb_wr_o, scb_stb_o SHALL be 0 in IDLE, DATn and RSP.

Reset
- REQ-034: rst_i=1 at an edge SHALL force IDLE, discard any in-flight request without a response, and set every output to 0 except req_ready_o=1.
- REQ-035: Reset SHALL take priority over scb_rdy_i and req_valid_i on the same edge.

Configuration
- REQ-036: SCB_INIT_SPLIT_EN defined SHALL enable odd-address word splitting per REQ-030.
- REQ-037: Without SCB_INIT_SPLIT_EN, an odd-address word request SHALL issue no bus cycle and go directly to RSP with rsp_err_o=1, rsp_rdata_o=0.

Structure
- REQ-038: Package scb_pkg SHALL hold A/D/B width constants, the FSM state enumeration and the timeout constant (255).
- REQ-039: Lane steering and extraction SHALL be one sub-module, scb_lane_mux; the FSM, counter and registers stay in scb_initiator.

Verification
- REQ-040: Word write 0x0124 data 0xBEEF, then word read, rdy tied 1 -> stb=11, Addr=0x124; rsp at N+2 / N+3; rdata=0xBEEF.
- REQ-041: Byte write 0x0125=0x5A, then byte read -> stb=10, Data_o=0x5A5A; rdata=0x005A.
- REQ-042: With the split macro, word read at 0x7FF (mem[0x7FF]=0x11, mem[0x000]=0x22) -> two cycles on Addr 0x7FF then 0x000; rdata=0x2211, err=0.
- REQ-043: rdy held 0 for 3 cycles on a write -> strobes stable 4 cycles, one rsp, err=0; rdy held 0 for 255 cycles -> err=1, strobes drop.
- REQ-044: rst_i asserted during DAT1 -> next cycle all outputs 0, req_ready_o=1, no rsp_valid_o; without the macro, odd word request -> no scb_ce_o, err=1.

Source files
------------

// File: rtl/scb_pkg.sv
// Shared widths, FSM state codes and the bus wait-timeout limit for the SCB initiator.
package scb_pkg;

    localparam int unsigned SCB_A = 11;
    localparam int unsigned SCB_D = 16;
    localparam int unsigned SCB_B = SCB_D / 8;

    localparam logic [7:0] SCB_TIMEOUT = 8'd255;

    typedef logic [2:0] scb_state_t;

    localparam scb_state_t S_IDLE = 3'd0;
    localparam scb_state_t S_CYC1 = 3'd1;
    localparam scb_state_t S_DAT1 = 3'd2;
    localparam scb_state_t S_CYC2 = 3'd3;
    localparam scb_state_t S_DAT2 = 3'd4;
    localparam scb_state_t S_RSP  = 3'd5;

endpackage

// File: rtl/scb_lane_mux.sv
// Byte-lane steering for the next SCB bus cycle and read-lane extraction
// for the cycle just completed.
module scb_lane_mux
    import scb_pkg::*;
#(
    parameter int unsigned D = SCB_D,
    parameter int unsigned B = SCB_B
) (
    input  logic         word_i,
    input  logic         odd_i,
    input  logic         hi_phase_i,
    input  logic [D-1:0] wdata_i,
    output logic [B-1:0] stb_o,
    output logic [D-1:0] wdata_o,
    input  logic         cap_word_i,
    input  logic         cap_odd_i,
    input  logic [D-1:0] bus_rdata_i,
    output logic [D-1:0] cap_o
);

    logic [7:0] wbyte;
    logic [7:0] rbyte;

    always_comb begin
        // the second half of a split word carries the request's high byte
        wbyte = hi_phase_i ? wdata_i[15:8] : wdata_i[7:0];
        if (word_i) begin
            stb_o   = '1;
            wdata_o = wdata_i;
        end else begin
            stb_o   = odd_i ? B'(2) : B'(1);
            wdata_o = {B{wbyte}};
        end
    end

    always_comb begin
        rbyte = cap_odd_i ? bus_rdata_i[15:8] : bus_rdata_i[7:0];
        if (cap_word_i) begin
            cap_o = bus_rdata_i;
        end else begin
            cap_o = {{(D-8){1'b0}}, rbyte};
        end
    end

endmodule

// File: rtl/scb_initiator.sv
// Request/response front end driving SCB byte/word bus cycles with a wait timeout.
// Define SCB_INIT_SPLIT_EN to split odd-address word accesses into two byte cycles.
module scb_initiator
    import scb_pkg::*;
#(
    parameter int unsigned A = SCB_A,
    parameter int unsigned D = SCB_D,
    parameter int unsigned B = SCB_B
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_wr_i,
    input  logic         req_word_i,
    input  logic [A-1:0] req_addr_i,
    input  logic [D-1:0] req_wdata_i,
    output logic         rsp_valid_o,
    output logic [D-1:0] rsp_rdata_o,
    output logic         rsp_err_o,
    output logic [A-1:0] scb_Addr_o,
    output logic [D-1:0] scb_Data_o,
    input  logic [D-1:0] scb_Data_i,
    output logic [B-1:0] scb_stb_o,
    output logic         scb_ce_o,
    output logic         scb_rd_o,
    output logic         scb_wr_o,
    input  logic         scb_rdy_i
);

`ifdef SCB_INIT_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    scb_state_t   state_q;
    logic         wr_q;
    logic         split_q;
    logic [A-1:0] addr_q;
    logic [D-1:0] wdata_q;
    logic [7:0]   lo_q;
    logic [7:0]   wait_q;
    logic         cyc_word_q;

    logic         odd_word_req;
    logic         in_cyc;
    logic         timeout;
    logic         load_cyc;
    logic         drop_cyc;
    logic         cyc_wr;
    logic         nxt_word;
    logic         nxt_hi;
    logic [A-1:0] nxt_addr;
    logic [D-1:0] nxt_wdata;
    logic [B-1:0] nxt_stb;
    logic [D-1:0] nxt_bus_wdata;
    logic [D-1:0] cap_data;

    assign req_ready_o  = (state_q == S_IDLE);
    assign odd_word_req = req_word_i & req_addr_i[0];
    assign in_cyc       = (state_q == S_CYC1) || (state_q == S_CYC2);
    assign timeout      = in_cyc && !scb_rdy_i && (wait_q == SCB_TIMEOUT - 8'd1);

    // A new bus cycle starts on accept, or for the second half of a split word.
    always_comb begin
        load_cyc = 1'b0;
        case (state_q)
            S_IDLE:  load_cyc = req_valid_i && !(odd_word_req && !SPLIT_EN);
            S_CYC1:  load_cyc = scb_rdy_i && wr_q && split_q;
            S_DAT1:  load_cyc = split_q;
            default: load_cyc = 1'b0;
        endcase
        drop_cyc = in_cyc && (scb_rdy_i || timeout) && !load_cyc;
    end

    always_comb begin
        if (state_q == S_IDLE) begin
            nxt_addr  = req_addr_i;
            nxt_word  = req_word_i & ~req_addr_i[0];
            nxt_hi    = 1'b0;
            nxt_wdata = req_wdata_i;
            cyc_wr    = req_wr_i;
        end else begin
            nxt_addr  = addr_q + A'(1);
            nxt_word  = 1'b0;
            nxt_hi    = 1'b1;
            nxt_wdata = wdata_q;
            cyc_wr    = wr_q;
        end
    end

    scb_lane_mux #(
        .D(D),
        .B(B)
    ) u_lane_mux (
        .word_i      (nxt_word),
        .odd_i       (nxt_addr[0]),
        .hi_phase_i  (nxt_hi),
        .wdata_i     (nxt_wdata),
        .stb_o       (nxt_stb),
        .wdata_o     (nxt_bus_wdata),
        .cap_word_i  (cyc_word_q),
        .cap_odd_i   (scb_Addr_o[0]),
        .bus_rdata_i (scb_Data_i),
        .cap_o       (cap_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scb_Addr_o <= '0;
            scb_Data_o <= '0;
            scb_stb_o  <= '0;
            scb_ce_o   <= 1'b0;
            scb_rd_o   <= 1'b0;
            scb_wr_o   <= 1'b0;
            cyc_word_q <= 1'b0;
            wait_q     <= '0;
        end else if (load_cyc) begin
            scb_Addr_o <= nxt_addr;
            scb_Data_o <= cyc_wr ? nxt_bus_wdata : '0;
            scb_stb_o  <= nxt_stb;
            scb_ce_o   <= 1'b1;
            scb_rd_o   <= ~cyc_wr;
            scb_wr_o   <= cyc_wr;
            cyc_word_q <= nxt_word;
            wait_q     <= '0;
        end else begin
            if (drop_cyc) begin
                scb_stb_o <= '0;
                scb_ce_o  <= 1'b0;
                scb_rd_o  <= 1'b0;
                scb_wr_o  <= 1'b0;
            end
            if (in_cyc && !scb_rdy_i && !timeout) begin
                wait_q <= wait_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            split_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        wr_q    <= req_wr_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        split_q <= odd_word_req & SPLIT_EN;
                        if (odd_word_req && !SPLIT_EN) begin
                            state_q     <= S_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state_q <= S_CYC1;
                        end
                    end
                end
                S_CYC1, S_CYC2: begin
                    if (scb_rdy_i) begin
                        if (!wr_q) begin
                            state_q <= (state_q == S_CYC1) ? S_DAT1 : S_DAT2;
                        end else if (state_q == S_CYC1 && split_q) begin
                            state_q <= S_CYC2;
                        end else begin
                            state_q     <= S_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_rdata_o <= '0;
                        end
                    end else if (timeout) begin
                        state_q     <= S_RSP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end
                end
                S_DAT1: begin
                    if (split_q) begin
                        lo_q    <= cap_data[7:0];
                        state_q <= S_CYC2;
                    end else begin
                        state_q     <= S_RSP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= cap_data;
                    end
                end
                S_DAT2: begin
                    state_q     <= S_RSP;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= {cap_data[7:0], lo_q};
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scb_initiator.sv
// Directed bench for scb_initiator with a byte-addressed memory responder.
// Build with SCB_INIT_SPLIT_EN defined to exercise odd-address word splitting.
module tb_scb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic        req_word;
    logic [10:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [10:0] scb_addr;
    logic [15:0] scb_dout;
    logic [15:0] scb_din;
    logic [1:0]  scb_stb;
    logic        scb_ce;
    logic        scb_rd;
    logic        scb_wr;
    logic        rdy;

    scb_initiator #(
        .A(11),
        .D(16),
        .B(2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_wr_i    (req_wr),
        .req_word_i  (req_word),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .scb_Addr_o  (scb_addr),
        .scb_Data_o  (scb_dout),
        .scb_Data_i  (scb_din),
        .scb_stb_o   (scb_stb),
        .scb_ce_o    (scb_ce),
        .scb_rd_o    (scb_rd),
        .scb_wr_o    (scb_wr),
        .scb_rdy_i   (rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] addr;
        logic [1:0]  stb;
        logic [15:0] data;
        logic        rd;
        logic        wr;
    } bus_t;

    logic [7:0] mem [0:2047];
    bus_t       bus_log[$];
    int         rsp_cnt;
    int         stall_left;
    int         checks;
    int         errors;
    int         r_lat;
    logic       r_got;
    logic [15:0] r_rdata;
    logic        r_err;
    logic [49:0] outs;

    // Memory responder: lane 0 is the even byte, lane 1 the odd byte.
    always @(posedge clk) begin
        if (scb_ce && rdy && scb_wr) begin
            if (scb_stb[0]) mem[{scb_addr[10:1], 1'b0}] <= scb_dout[7:0];
            if (scb_stb[1]) mem[{scb_addr[10:1], 1'b1}] <= scb_dout[15:8];
        end
        if (scb_ce && rdy && scb_rd) begin
            scb_din <= {mem[{scb_addr[10:1], 1'b1}], mem[{scb_addr[10:1], 1'b0}]};
        end
    end

    always @(negedge clk) begin
        if (scb_ce) begin
            bus_log.push_back({scb_addr, scb_stb, scb_dout, scb_rd, scb_wr});
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                rdy = 1'b1;
            end
        end else begin
            rdy = 1'b1;
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    task automatic run(input logic wr, input logic word, input logic [10:0] addr,
                       input logic [15:0] wd, input int budget);
        bus_log.delete();
        rsp_cnt = 0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_req: got %b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_wr    = wr;
        req_word  = word;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_got = 1'b0;
        r_lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r_lat   = i;
                r_rdata = rsp_rdata;
                r_err   = rsp_err;
                r_got   = 1'b1;
                break;
            end
        end
        checks++;
        if (r_got !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h: got no response expected one within %0d cycles", addr, budget);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        req_wr = 1'b1;
        req_word = 1'b1;
        req_addr = 11'h124;
        req_wdata = 16'hBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {rsp_valid, rsp_rdata, rsp_err, scb_addr, scb_dout, scb_stb, scb_ce, scb_rd, scb_wr};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (scb_ce !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority_ce: got %b expected 0", scb_ce);
        end
    endtask

    task automatic test_word_access();
        run(1'b1, 1'b1, 11'h124, 16'hBEEF, 20);
        checks++;
        if (bus_log.size() != 1) begin
            errors++;
            $display("FAIL word_wr_cycles: got %0d expected 1", bus_log.size());
        end else begin
            checks++;
            if (bus_log[0] !== {11'h124, 2'b11, 16'hBEEF, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL word_wr_bus: got %h expected %h", bus_log[0], {11'h124, 2'b11, 16'hBEEF, 1'b0, 1'b1});
            end
        end
        checks++;
        if (r_lat != 2 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL word_wr_rsp: got lat=%0d err=%b expected lat=2 err=0", r_lat, r_err);
        end
        run(1'b0, 1'b1, 11'h124, 16'h0000, 20);
        checks++;
        if (bus_log.size() != 1 || bus_log[0] !== {11'h124, 2'b11, 16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL word_rd_bus: got n=%0d %h expected n=1 %h", bus_log.size(), bus_log[0], {11'h124, 2'b11, 16'h0000, 1'b1, 1'b0});
        end
        checks++;
        if (r_lat != 3 || r_rdata !== 16'hBEEF || r_err !== 1'b0) begin
            errors++;
            $display("FAIL word_rd_rsp: got lat=%0d data=%h err=%b expected lat=3 data=beef err=0", r_lat, r_rdata, r_err);
        end
    endtask

    task automatic test_byte_access();
        run(1'b1, 1'b0, 11'h125, 16'h005A, 20);
        checks++;
        if (bus_log.size() != 1 || bus_log[0] !== {11'h125, 2'b10, 16'h5A5A, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL byte_wr_bus: got n=%0d %h expected n=1 %h", bus_log.size(), bus_log[0], {11'h125, 2'b10, 16'h5A5A, 1'b0, 1'b1});
        end
        run(1'b0, 1'b0, 11'h125, 16'h0000, 20);
        checks++;
        if (bus_log.size() != 1 || bus_log[0].stb !== 2'b10) begin
            errors++;
            $display("FAIL byte_rd_odd_stb: got n=%0d stb=%b expected n=1 stb=10", bus_log.size(), bus_log[0].stb);
        end
        checks++;
        if (r_lat != 3 || r_rdata !== 16'h005A || r_err !== 1'b0) begin
            errors++;
            $display("FAIL byte_rd_odd_rsp: got lat=%0d data=%h err=%b expected lat=3 data=005a err=0", r_lat, r_rdata, r_err);
        end
        run(1'b0, 1'b0, 11'h124, 16'h0000, 20);
        checks++;
        if (bus_log.size() != 1 || bus_log[0].stb !== 2'b01 || r_rdata !== 16'h00EF) begin
            errors++;
            $display("FAIL byte_rd_even: got stb=%b data=%h expected stb=01 data=00ef", bus_log[0].stb, r_rdata);
        end
    endtask

    task automatic test_wait_states();
        stall_left = 3;
        run(1'b1, 1'b0, 11'h010, 16'h0077, 20);
        checks++;
        if (bus_log.size() != 4) begin
            errors++;
            $display("FAIL wait_strobe_cycles: got %0d expected 4", bus_log.size());
        end else begin
            checks++;
            if (bus_log[3] !== bus_log[0] || bus_log[0] !== {11'h010, 2'b01, 16'h7777, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL wait_strobe_stable: got %h/%h expected %h", bus_log[0], bus_log[3], {11'h010, 2'b01, 16'h7777, 1'b0, 1'b1});
            end
        end
        checks++;
        if (r_lat != 5 || r_err !== 1'b0 || rsp_cnt != 1) begin
            errors++;
            $display("FAIL wait_rsp: got lat=%0d err=%b n=%0d expected lat=5 err=0 n=1", r_lat, r_err, rsp_cnt);
        end
    endtask

    task automatic test_timeout();
        stall_left = 1000;
        run(1'b0, 1'b1, 11'h124, 16'h0000, 400);
        stall_left = 0;
        checks++;
        if (bus_log.size() != 255) begin
            errors++;
            $display("FAIL timeout_strobe_cycles: got %0d expected 255", bus_log.size());
        end
        checks++;
        if (r_lat != 256 || r_err !== 1'b1 || r_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL timeout_rsp: got lat=%0d err=%b data=%h expected lat=256 err=1 data=0000", r_lat, r_err, r_rdata);
        end
        checks++;
        if (scb_ce !== 1'b0 || scb_stb !== 2'b00) begin
            errors++;
            $display("FAIL timeout_drop: got ce=%b stb=%b expected 0/00", scb_ce, scb_stb);
        end
    endtask

    task automatic test_reset_in_flight();
        rsp_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_word  = 1'b1;
        req_addr  = 11'h124;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (scb_ce !== 1'b0 || req_ready !== 1'b0 || scb_addr !== 11'h124) begin
            errors++;
            $display("FAIL dat1_state: got ce=%b ready=%b addr=%h expected 0/0/124", scb_ce, req_ready, scb_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        outs = {rsp_valid, rsp_rdata, rsp_err, scb_addr, scb_dout, scb_stb, scb_ce, scb_rd, scb_wr};
        checks++;
        if (outs !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL inflight_reset: got outs=%h ready=%b expected 0/1", outs, req_ready);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (rsp_cnt != 0) begin
            errors++;
            $display("FAIL inflight_no_rsp: got %0d expected 0", rsp_cnt);
        end
    endtask

`ifdef SCB_INIT_SPLIT_EN
    task automatic test_split_word();
        run(1'b1, 1'b0, 11'h7FF, 16'h0011, 20);
        run(1'b1, 1'b0, 11'h000, 16'h0022, 20);
        run(1'b0, 1'b1, 11'h7FF, 16'h0000, 20);
        checks++;
        if (bus_log.size() != 2) begin
            errors++;
            $display("FAIL split_rd_cycles: got %0d expected 2", bus_log.size());
        end else begin
            checks++;
            if (bus_log[0].addr !== 11'h7FF || bus_log[0].stb !== 2'b10 ||
                bus_log[1].addr !== 11'h000 || bus_log[1].stb !== 2'b01) begin
                errors++;
                $display("FAIL split_rd_bus: got %h/%b %h/%b expected 7ff/10 000/01",
                         bus_log[0].addr, bus_log[0].stb, bus_log[1].addr, bus_log[1].stb);
            end
        end
        checks++;
        if (r_lat != 5 || r_rdata !== 16'h2211 || r_err !== 1'b0) begin
            errors++;
            $display("FAIL split_rd_rsp: got lat=%0d data=%h err=%b expected lat=5 data=2211 err=0", r_lat, r_rdata, r_err);
        end
        run(1'b1, 1'b1, 11'h7FF, 16'hA1B2, 20);
        checks++;
        if (bus_log.size() != 2 || bus_log[0].data !== 16'hB2B2 || bus_log[1].data !== 16'hA1A1 || r_lat != 3) begin
            errors++;
            $display("FAIL split_wr: got n=%0d d0=%h d1=%h lat=%0d expected n=2 b2b2 a1a1 lat=3",
                     bus_log.size(), bus_log[0].data, bus_log[1].data, r_lat);
        end
        run(1'b0, 1'b0, 11'h000, 16'h0000, 20);
        checks++;
        if (r_rdata !== 16'h00A1) begin
            errors++;
            $display("FAIL split_wr_readback: got %h expected 00a1", r_rdata);
        end
    endtask
`else
    task automatic test_odd_word_error();
        run(1'b0, 1'b1, 11'h125, 16'h0000, 20);
        checks++;
        if (bus_log.size() != 0 || r_lat != 1 || r_err !== 1'b1 || r_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL odd_word_rd: got n=%0d lat=%0d err=%b data=%h expected n=0 lat=1 err=1 data=0000",
                     bus_log.size(), r_lat, r_err, r_rdata);
        end
        run(1'b1, 1'b1, 11'h7FF, 16'h1234, 20);
        checks++;
        if (bus_log.size() != 0 || r_err !== 1'b1) begin
            errors++;
            $display("FAIL odd_word_wr: got n=%0d err=%b expected n=0 err=1", bus_log.size(), r_err);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rsp_cnt = 0;
        stall_left = 0;
        rdy = 1'b1;
        scb_din = '0;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_word = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rst = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        test_reset();
        test_word_access();
        test_byte_access();
        test_wait_states();
        test_timeout();
        test_reset_in_flight();
`ifdef SCB_INIT_SPLIT_EN
        test_split_word();
`else
        test_odd_word_error();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
